// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU; one operation in flight.
// Optional macro ALU_ARB_RR_EN selects round-robin instead of fixed priority (requester 0 wins ties).
module alu_arbiter #(
    parameter int WL = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [3:0]    req0_sel,
    input  logic [WL-1:0] req0_a,
    input  logic [WL-1:0] req0_b,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [3:0]    req1_sel,
    input  logic [WL-1:0] req1_a,
    input  logic [WL-1:0] req1_b,
    output logic          rsp0_valid,
    input  logic          rsp0_ready,
    output logic [WL-1:0] rsp0_data,
    output logic          rsp0_err,
    output logic          rsp1_valid,
    input  logic          rsp1_ready,
    output logic [WL-1:0] rsp1_data,
    output logic          rsp1_err,
    output logic [3:0]    alu_sel,
    output logic [WL-1:0] alu_a,
    output logic [WL-1:0] alu_b,
    input  logic [WL-1:0] alu_out,
    output logic          busy
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [3:0]    r_alu_sel;
    logic [WL-1:0] r_alu_a;
    logic [WL-1:0] r_alu_b;
    logic [WL-1:0] r_result;
    logic          r_err;
    logic          r_owner;
    logic          r_last_grant;
    logic          w_grant;
    logic          w_req_hs;

    // w_grant: 0 selects requester 0, 1 selects requester 1
`ifdef ALU_ARB_RR_EN
    assign w_grant = (req0_valid && req1_valid) ? ~r_last_grant : ~req0_valid;
`else
    logic w_unused_last_grant;
    assign w_unused_last_grant = r_last_grant;
    assign w_grant = ~req0_valid;
`endif

    assign w_req_hs = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                req0_ready = req0_valid && !w_grant;
                req1_ready = req1_valid && w_grant;
                if (req0_valid || req1_valid) w_next = S_EXEC;
            end
            S_EXEC: w_next = S_RESP;
            S_RESP: begin
                rsp0_valid = !r_owner;
                rsp1_valid = r_owner;
                if ((!r_owner && rsp0_ready) || (r_owner && rsp1_ready)) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_alu_sel    <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_result     <= '0;
            r_err        <= 1'b0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            if (r_state == S_IDLE && w_req_hs) begin
                r_alu_sel    <= w_grant ? req1_sel : req0_sel;
                r_alu_a      <= w_grant ? req1_a   : req0_a;
                r_alu_b      <= w_grant ? req1_b   : req0_b;
                r_owner      <= w_grant;
                r_last_grant <= w_grant;
            end
            // Illegal opcodes return zero rather than whatever the ALU drives for them
            if (r_state == S_EXEC) begin
                if (r_alu_sel > 4'd10) begin
                    r_result <= '0;
                    r_err    <= 1'b1;
                end else begin
                    r_result <= alu_out;
                    r_err    <= 1'b0;
                end
            end
        end
    end

    assign alu_sel   = r_alu_sel;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign rsp0_data = r_result;
    assign rsp1_data = r_result;
    assign rsp0_err  = r_err;
    assign rsp1_err  = r_err;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, multi-cycle corner sequences,
// and a randomized phase checked by a transaction-level scoreboard.
module tb_alu_arbiter;
    localparam int WL = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0_valid = 0, req1_valid = 0;
    logic          req0_ready, req1_ready;
    logic [3:0]    req0_sel = 0, req1_sel = 0;
    logic [WL-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic          rsp0_valid, rsp1_valid;
    logic          rsp0_ready = 0, rsp1_ready = 0;
    logic [WL-1:0] rsp0_data, rsp1_data;
    logic          rsp0_err, rsp1_err;
    logic [3:0]    alu_sel;
    logic [WL-1:0] alu_a, alu_b, alu_out;
    logic          busy;

    int n_pass  = 0;
    int n_total = 0;
    int last_g  = 1;

    always #5 clk = ~clk;

    alu_arbiter #(.WL(WL)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out), .busy(busy)
    );

    // Stand-in for the shared ALU; illegal opcodes drive garbage the arbiter must hide
    function automatic logic [WL-1:0] alu_fn(logic [3:0] s, logic [WL-1:0] a, logic [WL-1:0] b);
        case (s)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a << b[4:0];
            4'd3:    return a >> b[4:0];
            4'd4:    return WL'($signed(a) >>> b[4:0]);
            4'd5:    return a * b;
            4'd6:    return a | b;
            4'd7:    return a & b;
            4'd8:    return ~(a | b);
            4'd9:    return a ^ b;
            4'd10:   return ~(a ^ b);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    assign alu_out = alu_fn(alu_sel, alu_a, alu_b);

    function automatic int arb(logic v0, logic v1, int last);
`ifdef ALU_ARB_RR_EN
        if (v0 && v1) return 1 - last;
`else
        if (v0 && v1) return 0;
`endif
        return v0 ? 0 : 1;
    endfunction

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endfunction

    function automatic logic rv(int rq);
        return (rq != 0) ? rsp1_valid : rsp0_valid;
    endfunction
    function automatic logic [WL-1:0] rd(int rq);
        return (rq != 0) ? rsp1_data : rsp0_data;
    endfunction
    function automatic logic re(int rq);
        return (rq != 0) ? rsp1_err : rsp0_err;
    endfunction

    task automatic drive_req(int rq, logic v, logic [3:0] s, logic [WL-1:0] a, logic [WL-1:0] b);
        if (rq == 0) begin req0_valid = v; req0_sel = s; req0_a = a; req0_b = b; end
        else         begin req1_valid = v; req1_sel = s; req1_a = a; req1_b = b; end
    endtask

    task automatic set_rsp_ready(int rq, logic v);
        if (rq == 0) rsp0_ready = v; else rsp1_ready = v;
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle
    task automatic run_op(int rq, logic [3:0] s, logic [WL-1:0] a, logic [WL-1:0] b, int hold,
                          logic [WL-1:0] exp_d, logic exp_e, string nm);
        drive_req(rq, 1'b1, s, a, b);
        #1;
        chk({nm, ".ready"}, {req1_ready, req0_ready}, (rq != 0) ? 2'b10 : 2'b01);
        @(posedge clk);
        #1 drive_req(rq, 1'b0, 4'($urandom), $urandom, $urandom);
        @(negedge clk);
        chk({nm, ".exec"}, {busy, rsp1_valid, rsp0_valid, req1_ready, req0_ready}, 5'b10000);
        chk({nm, ".alu_regs"}, {alu_sel, alu_a, alu_b}, {s, a, b});
        @(negedge clk);
        chk({nm, ".rsp_valid"}, {rv(1 - rq), rv(rq)}, 2'b01);
        chk({nm, ".rsp"}, {re(rq), rd(rq)}, {exp_e, exp_d});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({nm, ".hold"}, {rv(rq), re(rq), rd(rq)}, {1'b1, exp_e, exp_d});
        end
        set_rsp_ready(rq, 1'b1);
        @(negedge clk);
        set_rsp_ready(rq, 1'b0);
        chk({nm, ".release"}, {busy, rsp1_valid, rsp0_valid}, 3'b000);
        chk({nm, ".alu_hold"}, alu_a, a);
        last_g = rq;
    endtask

    typedef struct {
        int         rq;
        logic [3:0] sel;
        logic [31:0] a, b;
        int         hold;
        logic [31:0] exp_d;
        logic       exp_e;
    } vec_t;

    vec_t vt[7];

    // Random-phase scoreboard state
    logic        out_busy;
    int          out_age, out_owner;
    logic [31:0] out_d;
    logic        out_e;

    initial begin
        vt[0] = '{0, 4'd0,  32'd5,    32'd7,    0, 32'd12,         1'b0};
        vt[1] = '{1, 4'd1,  32'd0,    32'd1,    5, 32'hFFFF_FFFF,  1'b0};
        vt[2] = '{0, 4'd12, 32'd3,    32'd4,    0, 32'd0,          1'b1};
        vt[3] = '{1, 4'd7,  32'hF0,   32'h3C,   1, 32'h30,         1'b0};
        vt[4] = '{0, 4'd9,  32'hF0,   32'h3C,   0, 32'hCC,         1'b0};
        vt[5] = '{1, 4'd10, 32'd0,    32'd0,    2, 32'hFFFF_FFFF,  1'b0};
        vt[6] = '{0, 4'd15, 32'd9,    32'd9,    0, 32'd0,          1'b1};

        #2;
        chk("reset_outputs", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, rsp0_err, rsp1_err},
            7'b0);
        chk("reset_regs", {alu_sel, alu_a, alu_b, rsp0_data}, '0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);

        foreach (vt[i]) run_op(vt[i].rq, vt[i].sel, vt[i].a, vt[i].b, vt[i].hold,
                               vt[i].exp_d, vt[i].exp_e, $sformatf("vec%0d", i));

        // Contention: both requesters valid continuously
        drive_req(0, 1'b1, 4'd7, 32'hF0, 32'h3C);
        drive_req(1, 1'b1, 4'd9, 32'hF0, 32'h3C);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            int g;
            g = arb(1'b1, 1'b1, last_g);
            #1;
            chk($sformatf("contend%0d.grant", k), {req1_ready, req0_ready}, (g != 0) ? 2'b10 : 2'b01);
            @(negedge clk);
            @(negedge clk);
            chk($sformatf("contend%0d.owner", k), {rv(1 - g), rv(g)}, 2'b01);
            chk($sformatf("contend%0d.data", k), rd(g), (g != 0) ? 32'hCC : 32'h30);
            if (k == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            @(negedge clk);
            last_g = g;
        end
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;

        // Back-pressure: req1 arrives while req0's op is in flight
        drive_req(0, 1'b1, 4'd0, 32'd1, 32'd2);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        drive_req(1, 1'b1, 4'd6, 32'h11, 32'h22);
        @(negedge clk);
        chk("bp.exec_ready", req1_ready, 1'b0);
        @(negedge clk);
        chk("bp.resp_ready", req1_ready, 1'b0);
        chk("bp.rsp0", {rsp0_valid, rsp0_data}, {1'b1, 32'd3});
        drive_req(1, 1'b1, 4'd1, 32'd100, 32'd58);
        rsp0_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0;
        chk("bp.idle_ready", {req1_ready, req0_ready}, 2'b10);
        @(posedge clk);
        #1 drive_req(1, 1'b0, 4'd3, 32'd7, 32'd7);
        @(negedge clk);
        chk("bp.operands", {alu_sel, alu_a, alu_b}, {4'd1, 32'd100, 32'd58});
        @(negedge clk);
        chk("bp.rsp1", {rsp1_valid, rsp0_valid, rsp1_err, rsp1_data}, {3'b100, 32'd42});
        rsp1_ready = 1'b1;
        @(negedge clk);
        rsp1_ready = 1'b0;
        last_g = 1;

        // Reset asserted during EXEC
        drive_req(0, 1'b1, 4'd0, 32'd1, 32'd1);
        @(posedge clk);
        #2 req0_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst.async", {busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready, alu_sel, alu_a, alu_b},
            '0);
        @(negedge clk) rst = 1'b1;
        rsp0_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst.no_rsp", {busy, rsp0_valid, rsp1_valid}, 3'b000);
        end
        rsp0_ready = 1'b0;
        last_g = 1;
        drive_req(0, 1'b1, 4'd9, 32'hF0, 32'h3C);
        drive_req(1, 1'b1, 4'd7, 32'hF0, 32'h3C);
        #1;
        chk("midrst.first_grant", {req1_ready, req0_ready}, 2'b01);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst.rsp0", {rsp0_valid, rsp1_valid, rsp0_data}, {2'b10, 32'hCC});
        rsp0_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0;
        last_g = 0;

        // Randomized phase against the transaction scoreboard
        out_busy = 1'b0;
        out_age = 0;
        out_owner = 0;
        out_d = 0;
        out_e = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            int g;
            logic er0, er1, req_hs, rsp_hs, ev;
            logic [3:0] s;
            logic [31:0] a, b;
            g = arb(req0_valid, req1_valid, last_g);
            er0 = !out_busy && req0_valid && g == 0;
            er1 = !out_busy && req1_valid && g == 1;
            chk("rand.ready", {req1_ready, req0_ready}, {er1, er0});
            chk("rand.busy", busy, out_busy);
            for (int n = 0; n < 2; n++) begin
                ev = out_busy && out_age >= 1 && out_owner == n;
                chk($sformatf("rand.rsp%0d_valid", n), rv(n), ev);
                if (ev) chk($sformatf("rand.rsp%0d", n), {re(n), rd(n)}, {out_e, out_d});
            end
            req_hs = er0 || er1;
            rsp_hs = out_busy && out_age >= 1 && ((out_owner == 0) ? rsp0_ready : rsp1_ready);
            s = (g == 0) ? req0_sel : req1_sel;
            a = (g == 0) ? req0_a : req1_a;
            b = (g == 0) ? req0_b : req1_b;
            @(posedge clk);
            if (out_busy) begin
                if (rsp_hs) out_busy = 1'b0;
                else out_age++;
            end
            if (req_hs) begin
                out_busy = 1'b1;
                out_age = 0;
                out_owner = g;
                last_g = g;
                out_e = (s > 4'd10);
                out_d = out_e ? 32'd0 : alu_fn(s, a, b);
            end
            #1;
            drive_req(0, ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)), $urandom, $urandom);
            drive_req(1, ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)), $urandom, $urandom);
            rsp0_ready = ($urandom_range(0, 2) != 0);
            rsp1_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
